// File: rtl/hazard_scoreboard_unit.sv
// Purpose: EX-stage operand forwarding select, ID-stage stall generation and a busy scoreboard for multi-cycle ops.
// Latency: fwd_sel and stall are combinational from the current inputs and scoreboard; busy and stall_cnt update on the next clk edge.
// Backpressure: stall holds PC/IF/ID and injects a bubble into EX; there is no other flow control.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   id_valid, id_rs, id_rs_used, id_rd, id_is_mc
//                             instruction in ID (sources packed REG_AW bits per slot)
//   ex_rd, ex_is_load, ex_rs  instruction in EX (load-use check and forwarding sources)
//   rdexmem, rwriteexmem      EX/MEM destination and write enable
//   rdmemwb, rwritememwb      MEM/WB destination and write enable
//   mc_done, mc_done_rd       multi-cycle unit result on its writeback bus
//   fwd_sel                   2 bits per EX slot: 00 RF, 01 EX/MEM, 10 MEM/WB, 11 mc bus
//   stall                     hazard detected in ID
//   busy                      per-register in-flight multi-cycle scoreboard
//   stall_cnt                 saturating count of stalled cycles
module hazard_scoreboard_unit #(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]   id_rs,
    input  logic [NUM_SRC-1:0]          id_rs_used,
    input  logic [REG_AW-1:0]           id_rd,
    input  logic                        id_is_mc,
    input  logic [REG_AW-1:0]           ex_rd,
    input  logic                        ex_is_load,
    input  logic [NUM_SRC*REG_AW-1:0]   ex_rs,
    input  logic [REG_AW-1:0]           rdexmem,
    input  logic                        rwriteexmem,
    input  logic [REG_AW-1:0]           rdmemwb,
    input  logic                        rwritememwb,
    input  logic                        mc_done,
    input  logic [REG_AW-1:0]           mc_done_rd,
    output logic [NUM_SRC*2-1:0]        fwd_sel,
    output logic                        stall,
    output logic [(1<<REG_AW)-1:0]      busy,
    output logic [CNT_W-1:0]            stall_cnt
);

    localparam int NREG = 1 << REG_AW;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [NREG-1:0] busy_nxt;
    logic            loaduse;
    logic            raw;
    logic            waw;

    // A result on the mc bus this cycle frees its register for the reader
    // in ID: by the time that instruction reaches EX the value is either
    // forwarded from the mc bus or already written through the regfile.
    function automatic logic mc_release(input logic [REG_AW-1:0] r);
        return mc_done && (mc_done_rd == r);
    endfunction

    // Forwarding select per EX slot; the youngest producer wins.
    always_comb begin
        logic [REG_AW-1:0] s;
        s       = REG_ZERO;
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            s = ex_rs[i*REG_AW +: REG_AW];
            if (s != REG_ZERO) begin
                if (rwriteexmem && (rdexmem == s)) begin
                    fwd_sel[i*2 +: 2] = 2'b01;
                end else if (rwritememwb && (rdmemwb == s)) begin
                    fwd_sel[i*2 +: 2] = 2'b10;
                end else if (mc_done && (mc_done_rd == s)) begin
                    fwd_sel[i*2 +: 2] = 2'b11;
                end
            end
        end
    end

    // ID-stage hazards. Unused source slots never contribute, and x0 can
    // never be a hazard because it is never written.
    always_comb begin
        logic [REG_AW-1:0] s;
        s       = REG_ZERO;
        loaduse = 1'b0;
        raw     = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            s = id_rs[i*REG_AW +: REG_AW];
            if (id_rs_used[i]) begin
                if (ex_is_load && (ex_rd != REG_ZERO) && (ex_rd == s)) begin
                    loaduse = 1'b1;
                end
                if ((s != REG_ZERO) && busy[s] && !mc_release(s)) begin
                    raw = 1'b1;
                end
            end
        end
        waw   = (id_rd != REG_ZERO) && busy[id_rd] && !mc_release(id_rd);
        stall = id_valid && (loaduse || raw || waw);
    end

    // Clear is applied before set so a new op issued to the register whose
    // previous result completes in the same cycle keeps it marked busy.
    always_comb begin
        busy_nxt = busy;
        if (mc_done && (mc_done_rd != REG_ZERO)) begin
            busy_nxt[mc_done_rd] = 1'b0;
        end
        if (id_valid && id_is_mc && !stall && (id_rd != REG_ZERO)) begin
            busy_nxt[id_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Performance counter saturates rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule
